// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer.
// Round counts for all AES key sizes let one sequencer serve every variant.
package aes_seq_pkg;

   localparam int unsigned NR_AES128 = 10;
   localparam int unsigned NR_AES192 = 12;
   localparam int unsigned NR_AES256 = 14;

   typedef enum logic [1:0] {
      RM_ADDKEY = 2'b00,
      RM_FULL   = 2'b01,
      RM_FINAL  = 2'b10
   } rnd_mode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_OUT
   } seq_state_t;

endpackage

// File: rtl/aes192_round_sequencer.sv
// Sequences one block through NR+1 round operations on an external round engine,
// driving the round-key select and returning the ciphertext over valid/ready.
module aes192_round_sequencer
   import aes_seq_pkg::*;
#(
   parameter int unsigned NR        = NR_AES192,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned ROUND_LAT = 1
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              key_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SEL_W-1:0]  rk_sel,
   output logic [1:0]        rnd_mode,
   output logic              rnd_start,
   output logic [DATA_W-1:0] rnd_state,
   input  logic [DATA_W-1:0] rnd_result,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              key_lost
);

   // ROUND_LAT is limited to 1..4, so a 2-bit latency counter always suffices.
   localparam logic [1:0]       LAT_LAST = 2'(ROUND_LAT - 1);
   localparam logic [SEL_W-1:0] NR_SEL   = SEL_W'(NR);

   seq_state_t        fsm_q, fsm_d;
   logic [SEL_W-1:0]  round_q, round_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0] state_q, state_d;
   logic              key_lost_q, key_lost_d;
   rnd_mode_t         mode;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         fsm_q      <= S_IDLE;
         round_q    <= '0;
         lat_cnt_q  <= '0;
         state_q    <= '0;
         key_lost_q <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         round_q    <= round_d;
         lat_cnt_q  <= lat_cnt_d;
         state_q    <= state_d;
         key_lost_q <= key_lost_d;
      end
   end

   always_comb begin
      fsm_d      = fsm_q;
      round_d    = round_q;
      lat_cnt_d  = lat_cnt_q;
      state_d    = state_q;
      key_lost_d = key_lost_q;
      in_ready   = 1'b0;
      rk_sel     = '0;
      mode       = RM_ADDKEY;
      rnd_start  = 1'b0;
      rnd_state  = '0;
      out_data   = '0;
      out_valid  = 1'b0;

      unique case (fsm_q)
         S_IDLE: begin
            // Gate with reset so nothing looks acceptable while reset is held.
            in_ready = key_ready & ap_rst_n;
            if (in_valid && in_ready) begin
               state_d    = in_data;
               round_d    = '0;
               lat_cnt_d  = '0;
               key_lost_d = 1'b0;
               fsm_d      = S_RUN;
            end
         end

         S_RUN: begin
            rk_sel    = round_q;
            rnd_state = state_q;
            rnd_start = (lat_cnt_q == 2'd0);
            if (round_q == '0) begin
               mode = RM_ADDKEY;
            end else if (round_q == NR_SEL) begin
               mode = RM_FINAL;
            end else begin
               mode = RM_FULL;
            end
            if (!key_ready) begin
               key_lost_d = 1'b1;
            end
            if (lat_cnt_q == LAT_LAST) begin
               state_d   = rnd_result;
               lat_cnt_d = '0;
               if (round_q == NR_SEL) begin
                  fsm_d = S_OUT;
               end else begin
                  round_d = round_q + SEL_W'(1);
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end

         S_OUT: begin
            out_valid = 1'b1;
            out_data  = state_q;
            if (!key_ready) begin
               key_lost_d = 1'b1;
            end
            if (out_ready) begin
               fsm_d = S_IDLE;
            end
         end

         default: begin
            fsm_d = S_IDLE;
         end
      endcase
   end

   assign rnd_mode = mode;
   assign busy     = (fsm_q != S_IDLE);
   assign key_lost = key_lost_q;

endmodule

// File: tb/tb_aes192_round_sequencer.sv
// Bench for aes192_round_sequencer: two instances (ROUND_LAT 1 and 3) wired to an
// AES-192 round-engine and key-mux model, checked against the FIPS-197 C.2 vector.
module tb_aes192_round_sequencer;

   localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

   typedef struct {
      logic [3:0] sel;
      logic [1:0] mode;
      logic       start;
   } rnd_vec_t;

   int n_vec = 0;
   int n_err = 0;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n;
   logic         key_ready;
   logic [127:0] rk_tab [0:15];

   logic [127:0] in_data, rnd_state, rnd_result, out_data;
   logic         in_valid, in_ready, rnd_start, out_valid, out_ready, busy, key_lost;
   logic [3:0]   rk_sel;
   logic [1:0]   rnd_mode;

   logic [127:0] in_data3, rnd_state3, rnd_result3, out_data3;
   logic         in_valid3, in_ready3, rnd_start3, out_valid3, out_ready3, busy3, key_lost3;
   logic [3:0]   rk_sel3;
   logic [1:0]   rnd_mode3;
   logic [1:0]   since3 = 2'd3;

   always #5 ap_clk = ~ap_clk;

   // ---------------- AES model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sb(input logic [7:0] a);
      logic [7:0] inv, base;
      inv  = 8'h01;
      base = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) inv = gm(inv, base);
         base = gm(base, base);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_rnd(input logic [127:0] st, input logic [1:0] mode,
                                            input logic [127:0] rk);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      if (mode == 2'b00) return st ^ rk;
      if (mode == 2'b11) return '0;
      for (int i = 0; i < 16; i++) b[i] = sb(st[127-8*i -: 8]);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
      if (mode == 2'b01) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
            t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
      return res ^ rk;
   endfunction

   // Single-cycle engine for the ROUND_LAT=1 instance.
   assign rnd_result = aes_rnd(rnd_state, rnd_mode, rk_tab[rk_sel]);

   // Three-cycle engine: result is only correct in the last cycle of a round.
   always @(posedge ap_clk) begin
      if (rnd_start3) since3 <= 2'd1;
      else if (since3 != 2'd3) since3 <= since3 + 2'd1;
   end
   assign rnd_result3 = (since3 == 2'd2) ? aes_rnd(rnd_state3, rnd_mode3, rk_tab[rk_sel3])
                                         : ~aes_rnd(rnd_state3, rnd_mode3, rk_tab[rk_sel3]);

   aes192_round_sequencer #(.ROUND_LAT(1)) u_dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .key_ready (key_ready),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rk_sel    (rk_sel),
      .rnd_mode  (rnd_mode),
      .rnd_start (rnd_start),
      .rnd_state (rnd_state),
      .rnd_result(rnd_result),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .key_lost  (key_lost)
   );

   aes192_round_sequencer #(.ROUND_LAT(3)) u_dut3 (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .key_ready (key_ready),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .rk_sel    (rk_sel3),
      .rnd_mode  (rnd_mode3),
      .rnd_start (rnd_start3),
      .rnd_state (rnd_state3),
      .rnd_result(rnd_result3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .busy      (busy3),
      .key_lost  (key_lost3)
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic accept1(input logic [127:0] pt);
      in_valid = 1'b1;
      in_data  = pt;
      #1;
      check("accept_in_ready", {127'd0, in_ready}, 128'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input bit on3, input int start, output int lat);
      lat = start;
      while (!(on3 ? out_valid3 : out_valid) && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake1();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // ---------------- test ----------------
   rnd_vec_t seq_tab [13];

   initial begin
      logic [31:0]  w [52];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      int           lat;
      bit           seen;

      for (int i = 0; i < 6; i++) w[i] = KEY[191-32*i -: 32];
      rc = 8'h01;
      for (int i = 6; i < 52; i++) begin
         tmp = w[i-1];
         if (i % 6 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-6] ^ tmp;
      end
      for (int r = 0; r < 16; r++)
         rk_tab[r] = (r < 13) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;

      for (int i = 0; i < 13; i++) begin
         seq_tab[i].sel   = 4'(i);
         seq_tab[i].mode  = (i == 0) ? 2'b00 : ((i == 12) ? 2'b10 : 2'b01);
         seq_tab[i].start = 1'b1;
      end

      ap_rst_n  = 1'b0;
      key_ready = 1'b1;
      in_valid  = 1'b0; in_data  = '0; out_ready  = 1'b0;
      in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;

      // Reset state
      #2;
      check("rst_in_ready", {127'd0, in_ready}, 128'd0);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_rk_sel", {124'd0, rk_sel}, 128'd0);
      check("rst_out_data", out_data, 128'd0);
      tick();
      ap_rst_n = 1'b1;
      #1;
      check("idle_in_ready", {127'd0, in_ready}, 128'd1);

      // C.2 vector with per-round sequence table, ROUND_LAT=1
      accept1(PT);
      for (int i = 0; i < 13; i++) begin
         check($sformatf("seq%0d_rk_sel", i), {124'd0, rk_sel}, {124'd0, seq_tab[i].sel});
         check($sformatf("seq%0d_mode", i), {126'd0, rnd_mode}, {126'd0, seq_tab[i].mode});
         check($sformatf("seq%0d_start", i), {127'd0, rnd_start}, {127'd0, seq_tab[i].start});
         check($sformatf("seq%0d_no_valid", i), {127'd0, out_valid}, 128'd0);
         tick();
      end
      check("lat13_out_valid", {127'd0, out_valid}, 128'd1);
      check("c2_ct", out_data, CT);
      check("c2_key_lost", {127'd0, key_lost}, 128'd0);
      check("out_rk_sel", {124'd0, rk_sel}, 128'd0);

      // Backpressure
      for (int k = 0; k < 20; k++) begin
         tick();
         check("bp_out_data", out_data, CT);
         check("bp_in_ready", {127'd0, in_ready}, 128'd0);
      end
      handshake1();
      check("post_hs_busy", {127'd0, busy}, 128'd0);
      check("post_hs_in_ready", {127'd0, in_ready}, 128'd1);

      // ROUND_LAT=3
      in_valid3 = 1'b1;
      in_data3  = PT;
      #1;
      check("lat3_in_ready", {127'd0, in_ready3}, 128'd1);
      tick();
      in_valid3 = 1'b0;
      for (int i = 0; i < 13; i++) begin
         for (int j = 0; j < 3; j++) begin
            check($sformatf("lat3_r%0d_c%0d_sel", i, j), {124'd0, rk_sel3}, 128'(i));
            check($sformatf("lat3_r%0d_c%0d_start", i, j), {127'd0, rnd_start3},
                  (j == 0) ? 128'd1 : 128'd0);
            check($sformatf("lat3_r%0d_c%0d_valid", i, j), {127'd0, out_valid3}, 128'd0);
            tick();
         end
      end
      check("lat39_out_valid", {127'd0, out_valid3}, 128'd1);
      check("lat3_ct", out_data3, CT);
      out_ready3 = 1'b1;
      tick();
      out_ready3 = 1'b0;
      check("lat3_idle", {127'd0, busy3}, 128'd0);

      // Reset during round 5
      accept1(PT);
      repeat (5) tick();
      check("pre_rst_round5", {124'd0, rk_sel}, 128'd5);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {127'd0, busy}, 128'd0);
      check("mid_rst_rk_sel", {124'd0, rk_sel}, 128'd0);
      check("mid_rst_mode", {126'd0, rnd_mode}, 128'd0);
      check("mid_rst_start", {127'd0, rnd_start}, 128'd0);
      check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("mid_rst_out_data", out_data, 128'd0);
      check("mid_rst_key_lost", {127'd0, key_lost}, 128'd0);
      check("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
      tick();
      ap_rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("post_rst_no_valid", {127'd0, seen}, 128'd0);
      accept1(PT);
      wait_valid(1'b0, 0, lat);
      check("post_rst_latency", 128'(lat), 128'd13);
      check("post_rst_ct", out_data, CT);
      handshake1();

      // key_ready low blocks acceptance
      key_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = PT;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("nokey_in_ready", {127'd0, in_ready}, 128'd0);
         tick();
         check("nokey_busy", {127'd0, busy}, 128'd0);
      end
      in_valid  = 1'b0;
      key_ready = 1'b1;

      // key_ready drops at round 4; out_ready held high in RUN
      out_ready = 1'b1;
      accept1(PT);
      repeat (4) tick();
      key_ready = 1'b0;
      tick();
      key_ready = 1'b1;
      wait_valid(1'b0, 5, lat);
      check("keylost_latency", 128'(lat), 128'd13);
      check("keylost_ct", out_data, CT);
      check("keylost_flag", {127'd0, key_lost}, 128'd1);
      tick();
      out_ready = 1'b0;
      check("keylost_idle", {127'd0, busy}, 128'd0);
      check("keylost_sticky_idle", {127'd0, key_lost}, 128'd1);

      accept1(PT);
      check("keylost_cleared", {127'd0, key_lost}, 128'd0);
      wait_valid(1'b0, 0, lat);
      check("final_ct", out_data, CT);
      check("final_key_lost", {127'd0, key_lost}, 128'd0);
      handshake1();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
